// File: rtl/serial_adder8.sv
// Bit-serial adder: one full-adder cell evaluated once per clock, LSB first,
// with a start/busy/done handshake and a held result.
module serial_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_sum;
  logic fa_carry;

  // The single full-adder cell; the only combinational path between registers.
  assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // NOTE: every register here is updated with <= so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            carry  <= cin;
            sum_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_carry;
          if (cnt == LAST) begin
            // Counter is held on the last bit so it never wraps mid-operation.
            sum   <= {fa_sum, sum_sr[WIDTH-1:1]};
            cout  <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
